// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared execute-to-memory pipeline types and widths
package cpu_pkg;

  localparam int ALU_W_DEF = 16;
  localparam int PC_W_DEF  = 32;
  localparam int SP_SEL_W  = 3;

  typedef struct packed {
    logic [1:0]          wb;
    logic                memRead;
    logic                memWrite;
    logic                en32;
    logic                isStack;
    logic                isPushPc;
    logic                isPrevSP;
    logic [SP_SEL_W-1:0] spSelect;
    logic [ALU_W_DEF-1:0] aluData;
    logic [PC_W_DEF-1:0] pc;
    logic [PC_W_DEF-1:0] storeData;
  } ex_mem_t;

  // A bubble must not trigger a memory access or a register write-back.
  function automatic ex_mem_t bubble(input ex_mem_t p);
    ex_mem_t q;
    q          = p;
    q.wb       = 2'b00;
    q.memRead  = 1'b0;
    q.memWrite = 1'b0;
    return q;
  endfunction

endpackage

// File: rtl/ex_mem_buffer.sv
// rtl/ex_mem_buffer.sv - execute-to-memory pipeline buffer with valid/ready handshake
// Define EX_MEM_SKID_EN for the two-entry skid buffer; otherwise a single register stage.
module ex_mem_buffer
  import cpu_pkg::*;
#(
  parameter int ALU_W = ALU_W_DEF,
  parameter int PC_W  = PC_W_DEF
) (
  input  logic       clk,
  input  logic       i_reset_n,
  input  logic       i_valid,
  output logic       o_ready,
  input  ex_mem_t    i_payload,
  output logic       o_valid,
  input  logic       i_ready,
  output ex_mem_t    o_payload,
  input  logic       i_flush,
  output logic [1:0] o_occupancy
);

  // Only the low ALU_W / PC_W bits are carried; upper bits of the fixed-width bundle read as zero.
  localparam int ALU_KEEP = (ALU_W < ALU_W_DEF) ? ALU_W : ALU_W_DEF;
  localparam int PC_KEEP  = (PC_W < PC_W_DEF) ? PC_W : PC_W_DEF;
  localparam logic [ALU_W_DEF-1:0] ALU_MASK = {ALU_W_DEF{1'b1}} >> (ALU_W_DEF - ALU_KEEP);
  localparam logic [PC_W_DEF-1:0]  PC_MASK  = {PC_W_DEF{1'b1}} >> (PC_W_DEF - PC_KEEP);

  ex_mem_t w_in;
  ex_mem_t r_main;
  logic    r_valid;
  logic    w_accept;
  logic    w_emit;
  logic    w_ready;

  always_comb begin
    w_in           = i_payload;
    w_in.aluData   = i_payload.aluData & ALU_MASK;
    w_in.pc        = i_payload.pc & PC_MASK;
    w_in.storeData = i_payload.storeData & PC_MASK;
  end

  assign w_accept = i_valid && w_ready;
  assign w_emit   = r_valid && i_ready;

`ifdef EX_MEM_SKID_EN
  ex_mem_t r_skid;
  logic    r_skid_valid;
  logic    r_ready;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b1;
    end else if (i_flush) begin
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b1;
    end else if (r_skid_valid) begin
      if (w_emit) begin
        r_main       <= r_skid;
        r_skid_valid <= 1'b0;
        r_ready      <= 1'b1;
      end
    end else if (w_accept && r_valid && !w_emit) begin
      r_skid       <= w_in;
      r_skid_valid <= 1'b1;
      r_ready      <= 1'b0;
    end else if (w_accept) begin
      r_main  <= w_in;
      r_valid <= 1'b1;
    end else if (w_emit) begin
      r_valid <= 1'b0;
    end
  end

  // Registered ready keeps i_ready out of the upstream timing path.
  assign w_ready     = r_ready;
  assign o_occupancy = {r_skid_valid, r_valid & ~r_skid_valid};
`else
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_main  <= '0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_main  <= w_in;
      r_valid <= 1'b1;
    end else if (w_emit) begin
      r_valid <= 1'b0;
    end
  end

  assign w_ready     = !r_valid || i_ready;
  assign o_occupancy = {1'b0, r_valid};
`endif

  assign o_ready   = w_ready;
  assign o_valid   = r_valid;
  assign o_payload = r_valid ? r_main : bubble(r_main);

endmodule

// File: tb/tb_ex_mem_buffer.sv
// tb/tb_ex_mem_buffer.sv - scoreboard bench for ex_mem_buffer (either EX_MEM_SKID_EN setting)
module tb_ex_mem_buffer;
  import cpu_pkg::*;

`ifdef EX_MEM_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic       clk;
  logic       i_reset_n;
  logic       i_valid;
  logic       o_ready;
  ex_mem_t    i_payload;
  logic       o_valid;
  logic       i_ready;
  ex_mem_t    o_payload;
  logic       i_flush;
  logic [1:0] o_occupancy;

  ex_mem_buffer dut (
    .clk         (clk),
    .i_reset_n   (i_reset_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_payload   (i_payload),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_payload   (o_payload),
    .i_flush     (i_flush),
    .o_occupancy (o_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  ex_mem_t     exp_q[$];
  logic [15:0] emit_log[$];
  ex_mem_t     hold_pl;
  bit          last_acc;
  bit          mon_en;
  int          seen_ff;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ex_mem_t rand_pl();
    ex_mem_t p;
    p.wb        = 2'($urandom);
    p.memRead   = 1'($urandom);
    p.memWrite  = 1'($urandom);
    p.en32      = 1'($urandom);
    p.isStack   = 1'($urandom);
    p.isPushPc  = 1'($urandom);
    p.isPrevSP  = 1'($urandom);
    p.spSelect  = 3'($urandom);
    p.aluData   = 16'($urandom);
    p.pc        = $urandom;
    p.storeData = $urandom;
    return p;
  endfunction

  function automatic ex_mem_t pl_alu(input logic [15:0] a);
    ex_mem_t p;
    p         = rand_pl();
    p.aluData = a;
    return p;
  endfunction

  // Reference: an in-order queue of held payloads with capacity CAP.
  always @(negedge clk) begin : monitor
    int      n;
    bit      m_ready;
    ex_mem_t exp_out;
    if (mon_en && i_reset_n) begin
      n       = exp_q.size();
      m_ready = (CAP == 2) ? (n < 2) : (n == 0 || i_ready);
      chk("o_ready", o_ready, m_ready);
      chk("o_valid", o_valid, n > 0);
      chk("o_occupancy", o_occupancy, n);
      if (n > 0) begin
        exp_out = exp_q[0];
      end else begin
        exp_out          = hold_pl;
        exp_out.wb       = 2'b00;
        exp_out.memRead  = 1'b0;
        exp_out.memWrite = 1'b0;
      end
      chk("o_payload", o_payload, exp_out);
      if (o_valid && i_ready) begin
        emit_log.push_back(o_payload.aluData);
        if (o_payload.aluData == 16'h00FF) seen_ff++;
      end
      if (i_flush) begin
        exp_q.delete();
        last_acc = 1'b0;
      end else begin
        if (n > 0 && i_ready) void'(exp_q.pop_front());
        last_acc = i_valid && m_ready;
        if (last_acc) exp_q.push_back(i_payload);
      end
      if (exp_q.size() > 0) hold_pl = exp_q[0];
    end
  end

  task automatic send(input ex_mem_t p, input int budget, output bit ok);
    int c = 0;
    i_payload = p;
    i_valid   = 1'b1;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (!last_acc && c < budget);
    ok = last_acc;
    if (ok) i_valid = 1'b0;
  endtask

  task automatic send_must(input ex_mem_t p);
    bit ok;
    send(p, 50, ok);
    chk("send_timeout", ok, 1'b1);
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    i_reset_n = 1'b0;
    i_valid   = 1'b0;
    i_flush   = 1'b0;
    exp_q.delete();
    hold_pl   = '0;
    last_acc  = 1'b0;
    #1;
    chk("rst_o_valid", o_valid, 1'b0);
    chk("rst_o_ready", o_ready, 1'b1);
    chk("rst_occupancy", o_occupancy, 2'd0);
    chk("rst_memWrite", o_payload.memWrite, 1'b0);
    chk("rst_payload", o_payload, '0);
    @(posedge clk);
    #2;
    mon_en    = 1'b1;
    i_reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int      base;
    bit      ok;
    ex_mem_t p;
    i_reset_n = 1'b1;
    i_valid   = 1'b0;
    i_ready   = 1'b0;
    i_flush   = 1'b0;
    i_payload = '0;
    hold_pl   = '0;
    last_acc  = 1'b0;
    mon_en    = 1'b0;
    seen_ff   = 0;
    do_reset();

    // first accept right after reset release
    i_ready = 1'b1;
    send_must(pl_alu(16'h0C01));
    chk("first_valid", o_valid, 1'b1);
    chk("first_alu", o_payload.aluData, 16'h0C01);
    idle(2);

    // streaming
    base = emit_log.size();
    for (int k = 1; k <= 8; k++) send_must(pl_alu(16'(k)));
    idle(3);
    chk("stream_count", emit_log.size() - base, 8);
    if (emit_log.size() >= base + 8)
      for (int k = 0; k < 8; k++) chk("stream_order", emit_log[base+k], 16'(k + 1));

    // backpressure
    base    = emit_log.size();
    i_ready = 1'b0;
    send_must(pl_alu(16'h00A1));
    send(pl_alu(16'h00A2), 3, ok);
    chk("bp_occupancy", o_occupancy, 2'(CAP));
    chk("bp_ready", o_ready, 1'b0);
    chk("bp_alu", o_payload.aluData, 16'h00A1);
    i_ready = 1'b1;
    if (!ok) send_must(i_payload);
    idle(4);
    chk("bp_count", emit_log.size() - base, 2);
    if (emit_log.size() >= base + 2) begin
      chk("bp_first", emit_log[base], 16'h00A1);
      chk("bp_second", emit_log[base+1], 16'h00A2);
    end

    // flush while holding entries
    i_ready = 1'b0;
    send_must(pl_alu(16'h00C1));
    send(pl_alu(16'h00C2), 3, ok);
    p         = pl_alu(16'h00FF);
    i_payload = p;
    i_valid   = 1'b1;
    i_flush   = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    chk("flush_valid", o_valid, 1'b0);
    chk("flush_occupancy", o_occupancy, 2'd0);
    chk("flush_ready", o_ready, 1'b1);
    i_ready = 1'b1;
    idle(4);
    chk("flush_ff_seen", seen_ff, 0);

    // bubble masking
    p          = pl_alu(16'h0BEE);
    p.memWrite = 1'b1;
    p.wb       = 2'b11;
    send_must(p);
    idle(2);
    chk("bubble_valid", o_valid, 1'b0);
    chk("bubble_memWrite", o_payload.memWrite, 1'b0);
    chk("bubble_wb", o_payload.wb, 2'b00);
    chk("bubble_alu", o_payload.aluData, 16'h0BEE);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      i_payload = rand_pl();
      i_valid   = ($urandom_range(3) != 0);
      i_ready   = ($urandom_range(2) != 0);
      i_flush   = ($urandom_range(19) == 0);
      @(posedge clk);
      #1;
    end
    i_flush = 1'b0;
    i_ready = 1'b1;
    idle(4);

    // reset in the middle of a transfer
    i_ready = 1'b0;
    send_must(pl_alu(16'h0D01));
    send(pl_alu(16'h0D02), 3, ok);
    base = emit_log.size();
    do_reset();
    i_ready = 1'b1;
    idle(3);
    chk("rst_no_emit", emit_log.size() - base, 0);
    send_must(pl_alu(16'h0E01));
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
